conv_result_reader: RTL and testbench
=====================================

# conv_result_reader

Reads the convolution result memory (MEMZ) once the convolution core has finished. Streams the sizeX+sizeY-1 result words to the host side over a valid/ready interface. It sits between MEMZ's read port and the host/AXI-side output path, and is the consumer of what the convolution core writes. It absorbs MEMZ's 1-cycle read latency and any output backpressure without losing or duplicating words.

## Interface
Parameters:
- DATA_WIDTH, 8, operand width; result words are 2*DATA_WIDTH bits
- ADDR_WIDTH, 5, width of sizeX/sizeY; MEMZ address is ADDR_WIDTH+1 bits

Ports:
- clk  in  1  single clock, rising edge
- rstn  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse that begins a readout; normally driven from the core's done_out
- config_in  in  2*ADDR_WIDTH  [ADDR_WIDTH-1:0]=sizeX, [2*ADDR_WIDTH-1:ADDR_WIDTH]=sizeY; sampled only when start is accepted
- memZ_addr  out  ADDR_WIDTH+1  MEMZ read address
- memZ_rd  out  1  MEMZ read enable; data is valid on dataZ in the following cycle
- dataZ  in  2*DATA_WIDTH  MEMZ read data
- out_data  out  2*DATA_WIDTH  result word
- out_valid  out  1  out_data is valid
- out_ready  in  1  downstream accepts the word; a transfer occurs when out_valid and out_ready are both high
- out_last  out  1  high together with the final word
- busy_out  out  1  readout in progress
- done_out  out  1  one-cycle pulse when the readout completes

## Operation
- Length: len = sizeX+sizeY-1, computed in ADDR_WIDTH+1 bits and latched at start. If sizeX==0 or sizeY==0, len = 0.
- FSM states:
  - IDLE: start accepted → if len==0 go to FIN, else go to READ.
  - READ: issue reads; after the read to address len-1 is issued → DRAIN.
  - DRAIN: wait until FIFO empty and nothing in flight → FIN.
  - FIN: done_out=1 for one cycle → IDLE.
- start is ignored outside IDLE; no re-sampling of config_in.
- Read address counter: cleared at start; increments by 1 on each issued read.
- Read issue rule (READ only): memZ_rd = (count + inflight - pop) < 2. count = FIFO occupancy (0..2); inflight = read issued last cycle; pop = out_valid & out_ready. This allows full rate and never overflows the FIFO.
- FIFO is 2 entries, registered output. out_valid = FIFO not empty. Push when the previous cycle had memZ_rd=1.
- out_last is high when the head word's index == len-1. The index is tracked by a separate pop counter.
- Once out_valid is high, out_data, out_valid and out_last stay stable until the transfer completes.
- busy_out is high in READ, DRAIN and FIN.

## Timing
- Reset values: memZ_addr=0, memZ_rd=0, out_data=0, out_valid=0, out_last=0, busy_out=0, done_out=0; FSM in IDLE; FIFO empty.
- start sampled at edge n: memZ_rd=1 with addr 0 in cycle n→n+1. dataZ is captured at edge n+2, so out_valid rises after edge n+2.
- With out_ready held high, one word per cycle. Total readout is len+3 cycles from the start edge to the done_out edge.
- done_out rises on the edge after the handshake of the last word. With len==0 it rises on the edge after start.
- Backpressure: with out_ready low, at most 2 words are buffered and memZ_rd drops. No word is lost or repeated.
- Reset asserted mid-readout: all state clears immediately; a pending read response is discarded; no done_out pulse.
- Maximum len = 2*(2^ADDR_WIDTH-1)-1, which fits in ADDR_WIDTH+1 bits with no wrap.

## Structure
- Shared package conv_pkg holds:
  - DATA_WIDTH/ADDR_WIDTH defaults
  - the config field offsets for sizeX/sizeY
  - the FSM state enum (IDLE, READ, DRAIN, FIN)
- One sub-module: result_fifo2, a 2-entry synchronous FIFO (push, pop, count, registered head) parameterised on width.

## Test plan
- sizeX=3, sizeY=2, MEMZ[0..3]=10,20,30,40, out_ready=1 → words 10,20,30,40 on consecutive cycles; out_last on 40; done_out one cycle later; busy_out drops after FIN.
- Same setup, out_ready toggling 1,0,0,1,... → identical word sequence; memZ_rd never issued with FIFO occupancy plus in-flight reads at 2 and no pop.
- sizeX=0, sizeY=5 → no memZ_rd; done_out pulses on the edge after start; out_valid stays 0.
- sizeX=31, sizeY=31 → 61 words, addresses 0..60; out_last on the word from address 60.
- start pulsed again during READ with different config_in → ignored; the original length completes.
- rstn low for one cycle after 2 of 4 words → all outputs return to reset values. A new start then produces all 4 words from address 0.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared defaults, config field layout and readout FSM states for the conv result path.
package conv_pkg;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 5;

    // config_in field positions, in units of ADDR_WIDTH
    localparam int CFG_SIZEX_FIELD = 0;
    localparam int CFG_SIZEY_FIELD = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } rd_state_t;
endpackage

// File: rtl/result_fifo2.sv
// Two-entry FIFO with registered head; push lands next cycle, pop frees a slot same cycle.
// Push is dropped when full without a pop; the caller throttles so that never happens.
module result_fifo2 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count
);
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] tail_q;
    logic [1:0]       cnt_q;
    logic             pop_ok;
    logic             push_ok;

    assign pop_ok  = pop && (cnt_q != 2'd0);
    assign push_ok = push && ((cnt_q != 2'd2) || pop_ok);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10: begin
                    if (cnt_q == 2'd0) head_q <= din;
                    else               tail_q <= din;
                    cnt_q <= cnt_q + 2'd1;
                end
                2'b01: begin
                    head_q <= tail_q;
                    cnt_q  <= cnt_q - 2'd1;
                end
                2'b11: begin
                    // occupancy unchanged; new word goes behind whatever stays
                    if (cnt_q == 2'd1) begin
                        head_q <= din;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= din;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head  = head_q;
    assign count = cnt_q;
endmodule

// File: rtl/conv_result_reader.sv
// Streams sizeX+sizeY-1 MEMZ result words to a valid/ready port after start; first word 2 cycles after start.
// A 2-deep FIFO absorbs the MEMZ read latency; reads stall under backpressure so nothing is lost or repeated.
module conv_result_reader
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      start,
    input  logic [2*ADDR_WIDTH-1:0]   config_in,
    output logic [ADDR_WIDTH:0]       memZ_addr,
    output logic                      memZ_rd,
    input  logic [2*DATA_WIDTH-1:0]   dataZ,
    output logic [2*DATA_WIDTH-1:0]   out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_last,
    output logic                      busy_out,
    output logic                      done_out
);
    localparam int LW = ADDR_WIDTH + 1;

    rd_state_t               state_q;
    rd_state_t               state_d;
    logic [LW-1:0]           len_q;
    logic [LW-1:0]           len_m1;
    logic [LW-1:0]           len_calc;
    logic [LW-1:0]           addr_q;
    logic [LW-1:0]           pop_idx_q;
    logic                    inflight_q;
    logic [ADDR_WIDTH-1:0]   size_x;
    logic [ADDR_WIDTH-1:0]   size_y;
    logic [1:0]              fifo_count;
    logic                    pop;
    logic                    accept;

    assign size_x   = config_in[CFG_SIZEX_FIELD*ADDR_WIDTH +: ADDR_WIDTH];
    assign size_y   = config_in[CFG_SIZEY_FIELD*ADDR_WIDTH +: ADDR_WIDTH];
    assign len_calc = ((size_x == '0) || (size_y == '0)) ? '0
                    : ({1'b0, size_x} + {1'b0, size_y} - LW'(1));
    assign len_m1   = len_q - LW'(1);
    assign accept   = (state_q == IDLE) && start;

    assign out_valid = (fifo_count != 2'd0);
    assign pop       = out_valid && out_ready;

    // words held (FIFO + in flight) minus this cycle's pop must leave room for one more
    assign memZ_rd = (state_q == READ) &&
                     (({1'b0, fifo_count} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (start) state_d = (len_calc == '0) ? FIN : READ;
            READ:  if (memZ_rd && (addr_q == len_m1)) state_d = DRAIN;
            DRAIN: if ((fifo_count == 2'd0) && !inflight_q) state_d = FIN;
            FIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            len_q      <= '0;
            addr_q     <= '0;
            pop_idx_q  <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= memZ_rd;
            if (accept) begin
                len_q     <= len_calc;
                addr_q    <= '0;
                pop_idx_q <= '0;
            end else begin
                if (memZ_rd) addr_q    <= addr_q + LW'(1);
                if (pop)     pop_idx_q <= pop_idx_q + LW'(1);
            end
        end
    end

    result_fifo2 #(
        .WIDTH (2*DATA_WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (inflight_q),
        .pop   (pop),
        .din   (dataZ),
        .head  (out_data),
        .count (fifo_count)
    );

    assign memZ_addr = addr_q;
    assign out_last  = out_valid && (pop_idx_q == len_m1);
    assign busy_out  = (state_q != IDLE);
    assign done_out  = (state_q == FIN);
endmodule

// File: tb/tb_conv_result_reader.sv
// Randomized bench for conv_result_reader against a queue-based model of the expected word stream.
module tb_conv_result_reader;
    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic [9:0]  config_in;
    logic [5:0]  memZ_addr;
    logic        memZ_rd;
    logic [15:0] dataZ;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy_out;
    logic        done_out;

    conv_result_reader dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .config_in (config_in),
        .memZ_addr (memZ_addr),
        .memZ_rd   (memZ_rd),
        .dataZ     (dataZ),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy_out  (busy_out),
        .done_out  (done_out)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int rdy_mode = 0;

    logic [15:0] mem [0:63];
    logic [16:0] cap_q [$];
    int          rd_q  [$];
    int issued, xfer, done_cnt, done_cyc, first_vld, first_rd;
    bit          stall_prev;
    logic [15:0] prev_dat;
    logic        prev_last;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc++;

    // MEMZ model: one-cycle read latency, junk on the bus when not read
    always @(posedge clk) dataZ <= memZ_rd ? mem[memZ_addr] : 16'($urandom);

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ((cyc % 3) == 0);
            default: out_ready = 1'($urandom);
        endcase
    end

    always @(negedge clk) begin
        if (rstn) begin
            if (memZ_rd) begin
                check_eq("rd_limit", 32'((issued - xfer + 1 - int'(out_valid && out_ready)) <= 2), 1);
                rd_q.push_back(int'(memZ_addr));
                if (first_rd < 0) first_rd = cyc;
                issued++;
            end
            if (stall_prev) begin
                check_eq("hold_vld", 32'(out_valid), 1);
                check_eq("hold_dat", 32'(out_data), 32'(prev_dat));
                check_eq("hold_last", 32'(out_last), 32'(prev_last));
            end
            if (out_valid && first_vld < 0) first_vld = cyc;
            if (out_valid && out_ready) begin
                cap_q.push_back({out_last, out_data});
                xfer++;
            end
            stall_prev = out_valid && !out_ready;
            prev_dat   = out_data;
            prev_last  = out_last;
            if (done_out) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic clear_monitor();
        cap_q.delete();
        rd_q.delete();
        issued = 0; xfer = 0; done_cnt = 0; done_cyc = -1;
        first_vld = -1; first_rd = -1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_addr"}, 32'(memZ_addr), 0);
        check_eq({tag, "_rd"},   32'(memZ_rd), 0);
        check_eq({tag, "_dat"},  32'(out_data), 0);
        check_eq({tag, "_vld"},  32'(out_valid), 0);
        check_eq({tag, "_last"}, 32'(out_last), 0);
        check_eq({tag, "_busy"}, 32'(busy_out), 0);
        check_eq({tag, "_done"}, 32'(done_out), 0);
    endtask

    task automatic run_case(input int sx, input int sy, input int mode,
                            input bit directed, input bit restart);
        int len, n, to, nw;
        logic [16:0] exp_w;
        len = (sx == 0 || sy == 0) ? 0 : sx + sy - 1;
        for (int i = 0; i < 64; i++) mem[i] = directed ? 16'((i + 1) * 10) : 16'($urandom);
        clear_monitor();
        rdy_mode  = mode;
        config_in = {5'(sy), 5'(sx)};
        start = 1'b1;
        tick();
        start = 1'b0;
        n = cyc;
        if (restart) begin
            tick();
            tick();
            config_in = {5'd1, 5'd1};
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        to = 0;
        while (done_cnt == 0 && to < 400) begin
            tick();
            to++;
        end
        if (done_cnt == 0) check_eq("timeout", 0, 1);
        tick();
        tick();
        check_eq("busy_after", 32'(busy_out), 0);
        check_eq("vld_after", 32'(out_valid), 0);
        check_eq("done_cnt", 32'(done_cnt), 1);
        check_eq("word_cnt", 32'(cap_q.size()), 32'(len));
        check_eq("rd_cnt", 32'(rd_q.size()), 32'(len));
        nw = (cap_q.size() < len) ? cap_q.size() : len;
        for (int i = 0; i < nw; i++) begin
            exp_w = {(i == len - 1), mem[i]};
            check_eq("word", 32'(cap_q[i]), 32'(exp_w));
        end
        for (int i = 0; i < rd_q.size() && i < len; i++) check_eq("rd_addr", 32'(rd_q[i]), 32'(i));
        if (mode == 0) begin
            if (len == 0) begin
                check_eq("done_edge0", 32'(done_cyc), 32'(n));
            end else begin
                check_eq("done_edge", 32'(done_cyc), 32'(n + len + 3));
                check_eq("first_rd", 32'(first_rd), 32'(n));
                check_eq("first_vld", 32'(first_vld), 32'(n + 2));
            end
        end
    endtask

    initial begin
        int to;
        rstn = 1'b0;
        start = 1'b0;
        config_in = '0;
        clear_monitor();
        stall_prev = 1'b0;
        tick();
        tick();
        check_reset_outputs("rst");
        rstn = 1'b1;
        tick();

        run_case(3, 2, 0, 1'b1, 1'b0);
        run_case(3, 2, 1, 1'b1, 1'b0);
        run_case(0, 5, 0, 1'b1, 1'b0);
        run_case(31, 31, 0, 1'b0, 1'b0);
        run_case(3, 2, 0, 1'b1, 1'b1);

        // reset partway through a readout
        clear_monitor();
        for (int i = 0; i < 64; i++) mem[i] = 16'((i + 1) * 10);
        rdy_mode = 0;
        config_in = {5'd2, 5'd3};
        start = 1'b1;
        tick();
        start = 1'b0;
        to = 0;
        while (cap_q.size() < 2 && to < 50) begin
            tick();
            to++;
        end
        if (cap_q.size() < 2) check_eq("rst_wait", 0, 1);
        rstn = 1'b0;
        #1;
        check_reset_outputs("midrst");
        tick();
        rstn = 1'b1;
        clear_monitor();
        tick();
        tick();
        check_eq("post_rst_vld", 32'(out_valid), 0);
        check_eq("post_rst_done", 32'(done_cnt), 0);
        run_case(3, 2, 0, 1'b1, 1'b0);

        for (int k = 0; k < 12; k++) begin
            run_case(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                     int'($urandom_range(0, 2)), 1'b0, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
